// File: rtl/idma_legalizer_req_arbiter.sv
// Round-robin arbiter sharing one 1D legalizer between NumReq request sources,
// with an in-order ID FIFO that steers each backend completion back to its issuer.
module idma_legalizer_req_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // requester side
  input  idma_req_t           req_i       [NumReq],
  input  logic [NumReq-1:0]   valid_i,
  output logic [NumReq-1:0]   ready_o,
  // legalizer side
  output idma_req_t           req_o,
  output logic                valid_o,
  input  logic                ready_i,
  // backend completion side
  input  idma_rsp_t           rsp_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  // per-requester completion side
  output idma_rsp_t           rsp_o       [NumReq],
  output logic [NumReq-1:0]   rsp_valid_o,
  input  logic [NumReq-1:0]   rsp_ready_i,
  // status
  output logic                busy_o,
  output logic [CntW-1:0]     num_outstanding_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  if (NumReq < 2) begin : g_num_req_check
    $error("idma_legalizer_req_arbiter: NumReq must be >= 2");
  end
  if (MaxOutstanding < 1) begin : g_max_outstanding_check
    $error("idma_legalizer_req_arbiter: MaxOutstanding must be >= 1");
  end

  function automatic idx_t idx_inc(idx_t i);
    return (32'(i) == NumReq - 1) ? idx_t'(0) : idx_t'(i + 1'b1);
  endfunction

  function automatic ptr_t ptr_inc(ptr_t p);
    return (32'(p) == MaxOutstanding - 1) ? ptr_t'(0) : ptr_t'(p + 1'b1);
  endfunction

  idx_t            rr_q;
  logic            lock_q;
  idx_t            lock_idx_q;
  idx_t            fifo_q [MaxOutstanding];
  ptr_t            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  idx_t winner, rr_cand, head;
  logic found, any_valid, full, empty, push, pop;

  // Winner: the locked index, else first valid at or after the rr pointer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    winner  = rr_q;
    rr_cand = rr_q;
    found   = 1'b0;
    if (lock_q) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        rr_cand = idx_t'((32'(rr_q) + i) % NumReq);
        if (valid_i[rr_cand] && !found) begin
          winner = rr_cand;
          found  = 1'b1;
        end
      end
    end
  end

  assign any_valid = |valid_i;
  assign full      = (count_q == CntW'(MaxOutstanding));
  assign empty     = (count_q == '0);

  // Gated by rst_ni so no request leaks to the legalizer while reset is held.
  assign valid_o   = rst_ni & any_valid & ~full;
  assign push      = valid_o & ready_i;
  assign req_o     = req_i[winner];

  always_comb begin
    ready_o = '0;
    if (push) ready_o[winner] = 1'b1;
  end

  assign head        = fifo_q[rd_ptr_q];
  assign rsp_ready_o = ~empty & rsp_ready_i[head];
  assign pop         = rsp_valid_i & rsp_ready_o;

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_valid_i && !empty) rsp_valid_o[head] = 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) rsp_o[i] = rsp_i;
  end

  assign busy_o            = (count_q != '0) | lock_q | valid_o;
  assign num_outstanding_o = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        rr_q     <= idx_inc(winner);
        lock_q   <= 1'b0;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end else if (valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= winner;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= winner;
  end

`ifndef SYNTHESIS
  idma_req_t lock_req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_req_q <= '0;
    end else begin
      if (valid_o && !ready_i) lock_req_q <= req_o;
      assert (!(rsp_valid_i && empty))
        else $error("completion received with no transfer outstanding");
      assert (!(push && full))
        else $error("push into full ID FIFO");
      if (lock_q) begin
        assert (valid_i[lock_idx_q])
          else $error("requester %0d withdrew valid while locked", lock_idx_q);
        assert (req_i[lock_idx_q] === lock_req_q)
          else $error("requester %0d changed req while locked", lock_idx_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_idma_legalizer_req_arbiter.sv
// Directed plus randomized bench; a queue-based reference model predicts every
// combinational output each cycle.
module tb_idma_legalizer_req_arbiter;

  localparam int N   = 4;
  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX + 1);

  typedef logic [15:0] req_t;
  typedef logic [7:0]  rsp_t;

  logic          clk    = 1'b0;
  logic          rst_ni = 1'b0;
  req_t          req_i [N];
  logic [N-1:0]  valid_i;
  logic [N-1:0]  ready_o;
  req_t          req_o;
  logic          valid_o;
  logic          ready_i;
  rsp_t          rsp_i;
  logic          rsp_valid_i;
  logic          rsp_ready_o;
  rsp_t          rsp_o [N];
  logic [N-1:0]  rsp_valid_o;
  logic [N-1:0]  rsp_ready_i;
  logic          busy_o;
  logic [CW-1:0] num_outstanding_o;

  always #5 clk = ~clk;

  idma_legalizer_req_arbiter #(
    .NumReq        (N),
    .MaxOutstanding(MAX),
    .idma_req_t    (req_t),
    .idma_rsp_t    (rsp_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .req_o            (req_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .rsp_i            (rsp_i),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_ready_o      (rsp_ready_o),
    .rsp_o            (rsp_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .busy_o           (busy_o),
    .num_outstanding_o(num_outstanding_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of issuing requester ids, rr pointer, pending lock.
  int mq[$];
  int rr         = 0;
  int lock       = -1;
  int last_grant = -1;

  // DUT outputs captured at the check point of the latest step.
  logic [N-1:0]  obs_ready, obs_rsp_valid;
  logic          obs_valid, obs_rsp_ready, obs_busy;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    mq.delete();
    rr         = 0;
    lock       = -1;
    last_grant = -1;
  endtask

  // One cycle: settle, compare against model, clock, advance model.
  task automatic step();
    bit           full, ev, hs, ers, pop;
    int           win, head;
    logic [N-1:0] er, erv;
    if (mq.size() == 0) rsp_valid_i = 1'b0;
    #1;
    full = (mq.size() == MAX);
    win  = -1;
    if (lock >= 0) win = lock;
    else
      for (int k = 0; k < N; k++)
        if (valid_i[(rr + k) % N] && win < 0) win = (rr + k) % N;
    ev = (valid_i != '0) && !full;
    hs = ev && ready_i;
    er = '0;
    if (hs) er[win] = 1'b1;
    head = (mq.size() > 0) ? mq[0] : 0;
    ers  = (mq.size() > 0) && rsp_ready_i[head];
    erv  = '0;
    if (rsp_valid_i && mq.size() > 0) erv[head] = 1'b1;
    pop = rsp_valid_i && ers;

    obs_ready = ready_o; obs_rsp_valid = rsp_valid_o; obs_valid = valid_o;
    obs_rsp_ready = rsp_ready_o; obs_busy = busy_o; obs_cnt = num_outstanding_o;

    chk("valid_o", 32'(valid_o), 32'(ev));
    chk("ready_o", 32'(ready_o), 32'(er));
    if (ev) chk("req_o", 32'(req_o), 32'(req_i[win]));
    chk("rsp_valid_o", 32'(rsp_valid_o), 32'(erv));
    chk("rsp_ready_o", 32'(rsp_ready_o), 32'(ers));
    chk("busy_o", 32'(busy_o), 32'((mq.size() != 0) || (lock >= 0) || ev));
    chk("num_outstanding_o", 32'(num_outstanding_o), 32'(mq.size()));
    for (int k = 0; k < N; k++) chk("rsp_o", 32'(rsp_o[k]), 32'(rsp_i));

    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (hs) begin
      mq.push_back(win);
      rr         = (win + 1) % N;
      lock       = -1;
      last_grant = win;
    end else begin
      last_grant = -1;
      if (ev) lock = win;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    valid_i     = '0;
    rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    repeat (MAX + 2) step();
    rsp_valid_i = 1'b0;
  endtask

  task automatic rand_inputs(input int rsp_pct);
    for (int k = 0; k < N; k++) begin
      if (!valid_i[k]) begin
        if ($urandom_range(2) == 0) begin
          valid_i[k] = 1'b1;
          req_i[k]   = 16'($urandom);
        end
      end else if (last_grant == k) begin
        valid_i[k] = 1'($urandom_range(1));
        req_i[k]   = 16'($urandom);
      end
    end
    ready_i     = ($urandom_range(3) != 0);
    rsp_valid_i = ($urandom_range(99) < rsp_pct);
    rsp_i       = 8'($urandom);
    rsp_ready_i = 4'($urandom);
  endtask

  initial begin
    for (int k = 0; k < N; k++) req_i[k] = req_t'(16'h1000 + k);
    valid_i     = '1;
    ready_i     = 1'b1;
    rsp_i       = 8'h5a;
    rsp_valid_i = 1'b1;
    rsp_ready_i = '1;

    // Reset state with all inputs active.
    @(negedge clk);
    #1;
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_ready_o", 32'(ready_o), 0);
    chk("rst_rsp_valid_o", 32'(rsp_valid_o), 0);
    chk("rst_rsp_ready_o", 32'(rsp_ready_o), 0);
    chk("rst_busy_o", 32'(busy_o), 0);
    chk("rst_count", 32'(num_outstanding_o), 0);
    @(negedge clk);
    rst_ni      = 1'b1;
    rsp_valid_i = 1'b0;
    model_reset();

    // Round-robin over all four requesters.
    begin
      logic [N-1:0] exp_seq [5];
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
      for (int s = 0; s < 5; s++) begin
        step();
        chk("rr_grant", 32'(obs_ready), 32'(exp_seq[s]));
        if (s == 4) chk("rr_fill4", 32'(obs_cnt), 4);
      end
    end
    drain();
    valid_i = 4'b1000;
    step();
    drain();

    // Lock holds requester 0 even when requester 2 rises.
    valid_i = 4'b0001;
    ready_i = 1'b0;
    step();
    valid_i = 4'b0101;
    step();
    step();
    chk("lock_no_ready", 32'(obs_ready), 0);
    ready_i = 1'b1;
    step();
    chk("lock_grant0", 32'(obs_ready), 32'(4'b0001));
    valid_i = 4'b0100;
    step();
    chk("lock_next2", 32'(obs_ready), 32'(4'b0100));
    drain();

    // Completion routing: issue from 2 then 0.
    valid_i = 4'b0100;
    step();
    valid_i = 4'b0001;
    step();
    valid_i     = '0;
    rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    step();
    chk("route_first", 32'(obs_rsp_valid), 32'(4'b0100));
    step();
    chk("route_second", 32'(obs_rsp_valid), 32'(4'b0001));
    rsp_valid_i = 1'b0;
    step();
    chk("route_cnt0", 32'(obs_cnt), 0);
    chk("route_idle", 32'(obs_busy), 0);

    // Head-of-line stall on requester 3.
    valid_i = 4'b1000;
    step();
    valid_i     = '0;
    rsp_valid_i = 1'b1;
    rsp_ready_i = 4'b0111;
    repeat (5) begin
      step();
      chk("hol_stall", 32'(obs_rsp_ready), 0);
      chk("hol_cnt", 32'(obs_cnt), 1);
    end
    rsp_ready_i = '1;
    step();
    chk("hol_release", 32'(obs_rsp_ready), 1);
    rsp_valid_i = 1'b0;
    step();
    chk("hol_cnt0", 32'(obs_cnt), 0);

    // Full: a same-cycle pop must not admit a push.
    valid_i = '1;
    repeat (MAX) step();
    step();
    chk("full_valid", 32'(obs_valid), 0);
    chk("full_ready", 32'(obs_ready), 0);
    chk("full_cnt", 32'(obs_cnt), MAX);
    rsp_valid_i = 1'b1;
    step();
    chk("full_pop_same", 32'(obs_valid), 0);
    rsp_valid_i = 1'b0;
    step();
    chk("full_pop_next", 32'(obs_valid), 1);
    drain();

    // Randomized traffic, first light then completion-starved.
    valid_i = '0;
    repeat (400) begin
      rand_inputs(60);
      step();
    end
    repeat (200) begin
      rand_inputs(10);
      step();
    end
    drain();
    ready_i = 1'b1;
    drain();

    // Reset in the middle of a burst.
    valid_i = '1;
    ready_i = 1'b1;
    repeat (3) step();
    valid_i     = '0;
    step();
    chk("mid_cnt3", 32'(obs_cnt), 3);
    valid_i     = '1;
    rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    rst_ni      = 1'b0;
    #1;
    chk("mid_rst_valid_o", 32'(valid_o), 0);
    chk("mid_rst_rsp_valid_o", 32'(rsp_valid_o), 0);
    chk("mid_rst_count", 32'(num_outstanding_o), 0);
    model_reset();
    @(negedge clk);
    rst_ni      = 1'b1;
    rsp_valid_i = 1'b0;
    step();
    chk("mid_first_grant", 32'(obs_ready), 32'(4'b0001));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
